cp0_timer_gen: RTL and testbench

Parametrised second-generation coprocessor 0 for the pipelined MIPS core, sitting at the M stage beside the exception-collection logic.
- Generalises interrupt width to NUM_HWINT external lines.
- Adds an internal Count/Compare timer interrupt source and a BadVAddr register for address exceptions.
- Keeps SR/Cause/EPC/PrID semantics and the EXL-op handshake with the PC unit.

---
 rtl/cp0_timer_gen_pkg.sv | 36 +++
 rtl/cp0_timer_gen_timer.sv | 32 +++
 rtl/cp0_timer_gen.sv | 125 ++++++++++++
 tb/tb_cp0_timer_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_timer_gen_pkg.sv
// rtl/cp0_timer_gen_pkg.sv - CP0 register ids, exception codes, instruction and EXL-op encodings
package cp0_timer_gen_pkg;

    typedef enum logic [2:0] {
        INSTR_NOP   = 3'd0,
        INSTR_MFC0  = 3'd1,
        INSTR_MTC0  = 3'd2,
        INSTR_ERET  = 3'd3,
        INSTR_OTHER = 3'd4
    } instr_t;

    typedef enum logic [1:0] {
        EXL_NONE  = 2'd0,
        EXL_ENTRY = 2'd1,
        EXL_ERET  = 2'd2
    } exlop_t;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/cp0_timer_gen_timer.sv
// rtl/cp0_timer_gen_timer.sv - Count/Compare timer with sticky TI pending bit
module cp0_timer
    import cp0_timer_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= COMPARE_RESET;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? wdata : count + 32'd1;
            // A Compare write acknowledges the timer and beats a same-cycle match
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_timer_gen.sv
// rtl/cp0_timer_gen.sv - M-stage coprocessor 0 with external interrupts, timer and BadVAddr
module cp0_timer_gen
    import cp0_timer_gen_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'hbaad_face
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          MPC,
    input  logic                 MBD,
    input  instr_t               instr,
    input  logic [4:0]           regid,
    input  logic [31:0]          WData,
    input  logic [31:0]          BadAddr,
    input  logic [NUM_HWINT-1:0] HWINT,
    input  logic [4:0]           EXC,
    output logic [31:0]          RData,
    output logic [31:0]          EPC,
    output exlop_t               EXLOp,
    output logic                 TimerIRQ
);

    logic        exl, ie, bd;
    logic [7:2]  im, ip, ip_now;
    logic [4:0]  exc_code;
    logic [31:0] epc_q, badvaddr, count, compare;
    logic        ti;
    logic        interrupt, exception, entry, mtc0_we;

    // With six external lines and the timer, line 5 shares bit 7 with TI
    always_comb begin
        ip_now = '0;
        ip_now[2 +: NUM_HWINT] = HWINT;
        if (TIMER_EN) ip_now[7] = ip_now[7] | ti;
    end

    assign interrupt = (|(im & ip_now)) && ie && !exl;
    assign exception = (EXC != EXC_INT);
    assign entry     = interrupt || exception;
    assign mtc0_we   = (instr == INSTR_MTC0) && !entry;

    always_comb begin
        EXLOp = EXL_NONE;
        if (entry)                    EXLOp = EXL_ENTRY;
        else if (instr == INSTR_ERET) EXLOp = EXL_ERET;
    end

    generate
        if (TIMER_EN) begin : g_timer
            cp0_timer u_timer (
                .clk        (clk),
                .reset      (reset),
                .count_we   (mtc0_we && regid == REG_COUNT),
                .compare_we (mtc0_we && regid == REG_COMPARE),
                .wdata      (WData),
                .count      (count),
                .compare    (compare),
                .ti         (ti)
            );
        end else begin : g_no_timer
            assign count   = '0;
            assign compare = '0;
            assign ti      = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exl      <= 1'b0;
            ie       <= 1'b1;
            im       <= 6'b111111;
            ip       <= '0;
            exc_code <= EXC_INT;
            bd       <= 1'b0;
            epc_q    <= '0;
            badvaddr <= '0;
        end else begin
            ip <= ip_now;
            if (entry) begin
                exl      <= 1'b1;
                bd       <= MBD;
                exc_code <= interrupt ? EXC_INT : EXC;
                epc_q    <= word_align(MBD ? MPC - 32'd4 : MPC);
                if (!interrupt && (EXC == EXC_ADEL || EXC == EXC_ADES))
                    badvaddr <= BadAddr;
            end else if (instr == INSTR_ERET) begin
                exl      <= 1'b0;
                exc_code <= EXC_INT;
                bd       <= 1'b0;
            end else if (mtc0_we) begin
                case (regid)
                    REG_SR: begin
                        im  <= WData[15:10];
                        exl <= WData[1];
                        ie  <= WData[0];
                    end
                    REG_EPC: epc_q <= word_align(WData);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        RData = '0;
        if (instr == INSTR_MFC0) begin
            case (regid)
                REG_BADVADDR: RData = badvaddr;
                REG_COUNT:    RData = count;
                REG_COMPARE:  RData = compare;
                REG_SR:       RData = {16'b0, im, 8'b0, exl, ie};
                REG_CAUSE:    RData = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
                REG_EPC:      RData = epc_q;
                REG_PRID:     RData = PRID_VAL;
                default:      RData = '0;
            endcase
        end
    end

    assign EPC      = epc_q;
    assign TimerIRQ = ti;

endmodule

// File: tb/tb_cp0_timer_gen.sv
// tb/tb_cp0_timer_gen.sv - directed self-checking bench for cp0_timer_gen
module tb_cp0_timer_gen;
    import cp0_timer_gen_pkg::*;

    localparam int NH = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   MPC, WData, BadAddr, RData, EPC;
    logic          MBD, TimerIRQ;
    instr_t        instr;
    logic [4:0]    regid, EXC;
    logic [NH-1:0] HWINT;
    exlop_t        EXLOp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cp0_timer_gen #(.NUM_HWINT(NH), .TIMER_EN(1'b1), .PRID_VAL(32'hbaad_face)) dut (
        .clk(clk), .reset(reset), .MPC(MPC), .MBD(MBD), .instr(instr), .regid(regid),
        .WData(WData), .BadAddr(BadAddr), .HWINT(HWINT), .EXC(EXC),
        .RData(RData), .EPC(EPC), .EXLOp(EXLOp), .TimerIRQ(TimerIRQ)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, output logic [31:0] d);
        instr = INSTR_MFC0;
        regid = r;
        #1;
        d = RData;
        instr = INSTR_NOP;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        instr = INSTR_MTC0;
        regid = r;
        WData = d;
        step();
        instr = INSTR_NOP;
    endtask

    task automatic do_eret;
        instr = INSTR_ERET;
        step();
        instr = INSTR_NOP;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1;
        step();
        step();
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL reset_sr got=%h exp=%h", d, 32'h0000_FC01); end
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_cause got=%h exp=0", d); end
        rd(REG_COMPARE, d);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_compare got=%h exp=ffffffff", d); end
        rd(REG_PRID, d);
        total++; if (d !== 32'hbaad_face) begin bad++; $display("FAIL prid got=%h exp=baadface", d); end
        rd(5'd10, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unimpl_read got=%h exp=0", d); end
        regid = REG_PRID;
        #1;
        total++; if (RData !== 32'h0) begin bad++; $display("FAIL rdata_not_mfc0 got=%h exp=0", RData); end
        total++; if (EPC !== 32'h0 || TimerIRQ !== 1'b0 || EXLOp !== EXL_NONE) begin
            bad++; $display("FAIL reset_outs got epc=%h ti=%b op=%0d exp epc=0 ti=0 op=0", EPC, TimerIRQ, EXLOp);
        end
        reset = 1'b0;
        step();
        wr(REG_SR, 32'h0000_FC03);
        wr(REG_COUNT, 32'h0000_1234);
        rd(REG_COUNT, d);
        total++; if (d !== 32'h0000_1234) begin bad++; $display("FAIL count_write got=%h exp=00001234", d); end
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC03) begin bad++; $display("FAIL sr_write got=%h exp=0000fc03", d); end
        #1;
        reset = 1'b1;
        #1;
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL async_reset_sr got=%h exp=0000fc01", d); end
        rd(REG_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL async_reset_count got=%h exp=0", d); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_hwint;
        logic [31:0] d;
        HWINT = 5'b00001;
        MPC   = 32'h0000_3010;
        MBD   = 1'b1;
        #1;
        total++; if (EXLOp !== EXL_ENTRY) begin bad++; $display("FAIL hwint_op got=%0d exp=%0d", EXLOp, EXL_ENTRY); end
        step();
        HWINT = '0;
        MBD   = 1'b0;
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h8000_0400) begin bad++; $display("FAIL hwint_cause got=%h exp=80000400", d); end
        total++; if (EPC !== 32'h0000_300C) begin bad++; $display("FAIL hwint_epc got=%h exp=0000300c", EPC); end
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC03) begin bad++; $display("FAIL hwint_sr got=%h exp=0000fc03", d); end
        total++; if (EXLOp !== EXL_NONE) begin bad++; $display("FAIL hwint_masked_op got=%0d exp=0", EXLOp); end
        instr = INSTR_ERET;
        #1;
        total++; if (EXLOp !== EXL_ERET) begin bad++; $display("FAIL eret_op got=%0d exp=%0d", EXLOp, EXL_ERET); end
        step();
        instr = INSTR_NOP;
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL eret_sr got=%h exp=0000fc01", d); end
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL eret_cause got=%h exp=0", d); end
    endtask

    task automatic test_adel;
        logic [31:0] d;
        EXC     = 5'd4;
        BadAddr = 32'h0000_1235;
        MPC     = 32'h0000_3000;
        #1;
        total++; if (EXLOp !== EXL_ENTRY) begin bad++; $display("FAIL adel_op got=%0d exp=%0d", EXLOp, EXL_ENTRY); end
        step();
        EXC = 5'd0;
        rd(REG_BADVADDR, d);
        total++; if (d !== 32'h0000_1235) begin bad++; $display("FAIL adel_badvaddr got=%h exp=00001235", d); end
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL adel_cause got=%h exp=00000010", d); end
        total++; if (EPC !== 32'h0000_3000) begin bad++; $display("FAIL adel_epc got=%h exp=00003000", EPC); end
        do_eret();
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC01) begin bad++; $display("FAIL adel_eret_sr got=%h exp=0000fc01", d); end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        int n;
        wr(REG_COUNT, 32'd0);
        wr(REG_COMPARE, 32'd10);
        n = 0;
        while (TimerIRQ !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++; if (n !== 10) begin bad++; $display("FAIL timer_latency got=%0d exp=10", n); end
        total++; if (EXLOp !== EXL_ENTRY) begin bad++; $display("FAIL timer_op got=%0d exp=%0d", EXLOp, EXL_ENTRY); end
        step();
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0000_8000) begin bad++; $display("FAIL timer_cause got=%h exp=00008000", d); end
        wr(REG_COMPARE, 32'd100);
        total++; if (TimerIRQ !== 1'b0) begin bad++; $display("FAIL timer_clear got=%b exp=0", TimerIRQ); end
        do_eret();
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL timer_eret_cause got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        wr(REG_EPC, 32'h0000_5003);
        total++; if (EPC !== 32'h0000_5000) begin bad++; $display("FAIL epc_write got=%h exp=00005000", EPC); end
        EXC   = 5'd12;
        instr = INSTR_MTC0;
        regid = REG_EPC;
        WData = 32'h0000_5000;
        MPC   = 32'h0000_3040;
        step();
        EXC   = 5'd0;
        instr = INSTR_NOP;
        total++; if (EPC !== 32'h0000_3040) begin bad++; $display("FAIL entry_wins_epc got=%h exp=00003040", EPC); end
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0000_0030) begin bad++; $display("FAIL entry_wins_cause got=%h exp=00000030", d); end
        do_eret();
        HWINT   = 5'b00010;
        EXC     = 5'd4;
        BadAddr = 32'hDEAD_0000;
        MPC     = 32'h0000_3080;
        step();
        HWINT = '0;
        EXC   = 5'd0;
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0000_0800) begin bad++; $display("FAIL int_over_exc_cause got=%h exp=00000800", d); end
        rd(REG_BADVADDR, d);
        total++; if (d !== 32'h0000_1235) begin bad++; $display("FAIL int_over_exc_badvaddr got=%h exp=00001235", d); end
        instr   = INSTR_ERET;
        EXC     = 5'd5;
        BadAddr = 32'h0000_2222;
        MPC     = 32'h0000_3100;
        #1;
        total++; if (EXLOp !== EXL_ENTRY) begin bad++; $display("FAIL eret_vs_exc_op got=%0d exp=%0d", EXLOp, EXL_ENTRY); end
        step();
        instr = INSTR_NOP;
        EXC   = 5'd0;
        rd(REG_CAUSE, d);
        total++; if (d !== 32'h0000_0014) begin bad++; $display("FAIL ades_cause got=%h exp=00000014", d); end
        rd(REG_BADVADDR, d);
        total++; if (d !== 32'h0000_2222) begin bad++; $display("FAIL ades_badvaddr got=%h exp=00002222", d); end
        rd(REG_SR, d);
        total++; if (d !== 32'h0000_FC03) begin bad++; $display("FAIL ades_sr got=%h exp=0000fc03", d); end
        do_eret();
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        wr(REG_COUNT, 32'hFFFF_FFFE);
        rd(REG_COUNT, d);
        total++; if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_0 got=%h exp=fffffffe", d); end
        step();
        rd(REG_COUNT, d);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_1 got=%h exp=ffffffff", d); end
        step();
        rd(REG_COUNT, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL wrap_2 got=%h exp=0", d); end
        wr(REG_COUNT, 32'h40);
        wr(REG_COMPARE, 32'h42);
        step();
        wr(REG_COMPARE, 32'h200);
        total++; if (TimerIRQ !== 1'b0) begin bad++; $display("FAIL match_clear got=%b exp=0", TimerIRQ); end
        step();
        total++; if (TimerIRQ !== 1'b0) begin bad++; $display("FAIL match_clear_hold got=%b exp=0", TimerIRQ); end
        rd(REG_COMPARE, d);
        total++; if (d !== 32'h200) begin bad++; $display("FAIL compare_read got=%h exp=00000200", d); end
    endtask

    initial begin
        reset   = 1'b1;
        MPC     = '0;
        MBD     = 1'b0;
        instr   = INSTR_NOP;
        regid   = '0;
        WData   = '0;
        BadAddr = '0;
        HWINT   = '0;
        EXC     = '0;
        test_reset();
        test_hwint();
        test_adel();
        test_timer();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
